udc_bcd_counter: RTL and testbench
==================================

# udc_bcd_counter

Multi-digit BCD up/down counter that sits directly downstream of the one-second tick timer in the UDC design. It consumes the timer's single-cycle `en` pulse and advances its count once per tick, up or down. A small start/stop state machine, a parallel load and a terminal-count pulse are included. Its `count` output feeds the seven-segment display driver.

## Interface
- `DIGITS`, default 4: number of BCD digits; count width is 4*DIGITS.
- `clk` input, 1 bit: system clock, all logic on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: one-cycle count tick from the upstream timer.
- `up` input, 1 bit: direction, 1 = increment, 0 = decrement; sampled at the tick edge.
- `start` input, 1 bit: one-cycle pulse, start or resume counting.
- `stop` input, 1 bit: one-cycle pulse, pause, or clear when already paused.
- `load` input, 1 bit: one-cycle pulse, load `load_val`.
- `load_val` input, 4*DIGITS bits: BCD load value, digit 0 in bits [3:0].
- `count` output, 4*DIGITS bits: registered BCD count.
- `tc` output, 1 bit: registered terminal-count pulse.
- `running` output, 1 bit: high while in state COUNT.

## Operation
- States:
  - IDLE: after reset, count held.
  - COUNT: ticks applied.
  - PAUSE: count held.
- State transitions:
  - IDLE, `start` -> COUNT.
  - COUNT, `stop` -> PAUSE.
  - PAUSE, `start` -> COUNT.
  - PAUSE, `stop` -> IDLE, and count clears to 0.
  - IDLE, `stop`: no effect.
  - `start` while in COUNT: ignored.
- Priority per cycle: `rst` > `load` > `start`/`stop` > `en`.
- If `start` and `stop` are asserted together, `stop` wins.
- `load` is honoured only in IDLE or PAUSE, and is ignored in COUNT.
- On load, the state is unchanged, `tc` = 0, and any `start`/`stop`/`en` in the same cycle is ignored.
- Each loaded digit greater than 9 is clamped to 9; for example, 0xA3F1 loads as 9391.
- Tick in COUNT with `up` = 1: BCD increment, ripple carry through digits.
  - 0099 -> 0100.
  - All-nines -> all-zeros with `tc` = 1.
- Tick in COUNT with `up` = 0: BCD decrement, ripple borrow.
  - 0100 -> 0099.
  - All-zeros -> all-nines with `tc` = 1.
- A tick in IDLE or PAUSE is ignored.
- A state-changing `start`/`stop` in the same cycle as `en` takes effect, and that tick is discarded.
- Digit arithmetic uses 4-bit values only; no binary intermediate wider than one digit plus carry.

## Timing
- Reset values: `count` = 0, `tc` = 0, `running` = 0, state IDLE.
- `rst` asserted mid-count overrides all inputs in that cycle.
- Latency: `count` reflects a tick, load or clear on the edge where it is sampled, so it is visible the cycle after the input is high.
- `tc` is high exactly one cycle, coincident with the wrapped `count` value, and is low every other cycle.
- `running` changes on the same edge as the state register.
- `en` held high for multiple cycles advances once per cycle; no edge detection is applied.
- `up` changing between ticks takes effect on the next tick; there is no hysteresis.

## Configuration
- Macro: `UDC_SATURATE_EN`.
- Defined (saturate instead of wrap):
  - A tick up at all-nines holds all-nines.
  - A tick down at all-zeros holds all-zeros.
  - In both cases `tc` pulses for one cycle and the state goes COUNT -> PAUSE, so `running` drops on the same edge.
- Undefined: wrap-around as described in Operation; state stays COUNT at wrap.

## Test plan
- Reset, `start`, 12 ticks with `up` = 1, DIGITS = 4 -> `count` = 0012, `running` = 1, `tc` never high.
- In PAUSE, load 0x9998, `start`, 3 ticks with `up` = 1 -> sequence 9999, 0000 (`tc` = 1 for one cycle), 0001.
  - With `UDC_SATURATE_EN` the sequence is instead 9999, 9999 (`tc` = 1), then PAUSE with `running` = 0.
- From 0100 in COUNT, `up` = 0, 2 ticks -> 0099, 0098.
  - From 0000 one down tick -> 9999 with `tc` = 1.
- In IDLE, load 0xA3F1 -> `count` = 9391.
  - `load` asserted in COUNT -> `count` unchanged.
- `stop` and `en` in the same cycle in COUNT at 0042 -> PAUSE, `count` stays 0042.
  - A second `stop` -> IDLE, `count` = 0000.
- `rst` asserted mid-count at 0517 in the same cycle as `en` -> `count` = 0000, `tc` = 0, `running` = 0 next cycle.

Source files
------------

// File: rtl/udc_bcd_counter.sv
// Multi-digit BCD up/down counter with start/stop/pause control, parallel load and terminal-count pulse.
// Optional build macro UDC_SATURATE_EN: saturate at all-nines/all-zeros and pause instead of wrapping.
module udc_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  running
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t         state_r;
  logic [W-1:0]   count_r;
  logic           tc_r;
  logic           running_r;

  logic [W-1:0]   inc_val_s;
  logic           inc_wrap_s;
  logic [W-1:0]   dec_val_s;
  logic           dec_wrap_s;
  logic [W-1:0]   clamp_val_s;

  // Ripple-carry increment, one 4-bit digit at a time; MSB of result flags all-nines wrap.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return {c, r};
  endfunction

  // Ripple-borrow decrement; MSB of result flags all-zeros wrap.
  function automatic logic [W:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    logic [3:0]   d;
    r = '0;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          b           = 1'b1;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          b           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return {b, r};
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-value arithmetic for tick and load paths.
  always_comb begin
    {inc_wrap_s, inc_val_s} = bcd_inc(count_r);
    {dec_wrap_s, dec_val_s} = bcd_dec(count_r);
    clamp_val_s             = bcd_clamp(load_val);
  end

  // Control FSM with registered count, tc and running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= '0;
      tc_r      <= 1'b0;
      running_r <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (load && (state_r != COUNT)) begin
        count_r <= clamp_val_s;
      end else begin
        case (state_r)
          IDLE: begin
            if (start && !stop) begin
              state_r   <= COUNT;
              running_r <= 1'b1;
            end else begin
              state_r   <= IDLE;
              running_r <= 1'b0;
            end
          end
          COUNT: begin
            if (stop) begin
              state_r   <= PAUSE;
              running_r <= 1'b0;
            end else if (en) begin
              if (up) begin
                if (inc_wrap_s) begin
                  tc_r <= 1'b1;
`ifdef UDC_SATURATE_EN
                  state_r   <= PAUSE;
                  running_r <= 1'b0;
`else
                  count_r   <= inc_val_s;
`endif
                end else begin
                  count_r <= inc_val_s;
                end
              end else begin
                if (dec_wrap_s) begin
                  tc_r <= 1'b1;
`ifdef UDC_SATURATE_EN
                  state_r   <= PAUSE;
                  running_r <= 1'b0;
`else
                  count_r   <= dec_val_s;
`endif
                end else begin
                  count_r <= dec_val_s;
                end
              end
            end else begin
              state_r <= COUNT;
            end
          end
          PAUSE: begin
            // stop from PAUSE is a clear; stop beats a simultaneous start
            if (stop) begin
              state_r   <= IDLE;
              count_r   <= '0;
              running_r <= 1'b0;
            end else if (start) begin
              state_r   <= COUNT;
              running_r <= 1'b1;
            end else begin
              state_r <= PAUSE;
            end
          end
          default: begin
            state_r   <= IDLE;
            running_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = count_r;
  assign tc      = tc_r;
  assign running = running_r;

endmodule

// File: tb/tb_udc_bcd_counter.sv
// Directed self-checking bench for udc_bcd_counter (DIGITS = 4); honours UDC_SATURATE_EN.
module tb_udc_bcd_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        start;
  logic        stop;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc;
  logic        running;

  int pass_cnt;
  int total_cnt;

  udc_bcd_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic p, input logic l,
                      input logic [15:0] lv, input logic e, input logic u);
    rst = r; start = s; stop = p; load = l; load_val = lv; en = e; up = u;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 16'h0000) $display("FAIL reset_count: got %h want %h", count, 16'h0000); else pass_cnt++;
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL reset_tc: got %b want %b", tc, 1'b0); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL reset_running: got %b want %b", running, 1'b0); else pass_cnt++;
  endtask

  task automatic test_count_up();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      total_cnt++;
      if (tc !== 1'b0) $display("FAIL up12_tc_low: tick %0d got %b want %b", i, tc, 1'b0); else pass_cnt++;
    end
    total_cnt++;
    if (count !== 16'h0012) $display("FAIL up12_count: got %h want %h", count, 16'h0012); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b1) $display("FAIL up12_running: got %b want %b", running, 1'b1); else pass_cnt++;
  endtask

  task automatic test_wrap_up();
    logic [15:0] exp_c [3];
    logic        exp_t [3];
    logic        exp_r [3];
    // Continues from COUNT at 0012: pause, load, resume.
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h9998, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 16'h9998) $display("FAIL pause_load: got %h want %h", count, 16'h9998); else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef UDC_SATURATE_EN
    exp_c[0] = 16'h9999; exp_t[0] = 1'b0; exp_r[0] = 1'b1;
    exp_c[1] = 16'h9999; exp_t[1] = 1'b1; exp_r[1] = 1'b0;
    exp_c[2] = 16'h9999; exp_t[2] = 1'b0; exp_r[2] = 1'b0;
`else
    exp_c[0] = 16'h9999; exp_t[0] = 1'b0; exp_r[0] = 1'b1;
    exp_c[1] = 16'h0000; exp_t[1] = 1'b1; exp_r[1] = 1'b1;
    exp_c[2] = 16'h0001; exp_t[2] = 1'b0; exp_r[2] = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      total_cnt++;
      if (count !== exp_c[i]) $display("FAIL wrap_up_count: tick %0d got %h want %h", i, count, exp_c[i]); else pass_cnt++;
      total_cnt++;
      if (tc !== exp_t[i]) $display("FAIL wrap_up_tc: tick %0d got %b want %b", i, tc, exp_t[i]); else pass_cnt++;
      total_cnt++;
      if (running !== exp_r[i]) $display("FAIL wrap_up_running: tick %0d got %b want %b", i, running, exp_r[i]); else pass_cnt++;
    end
  endtask

  task automatic test_count_down();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    total_cnt++;
    if (count !== 16'h0099) $display("FAIL down_0099: got %h want %h", count, 16'h0099); else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    total_cnt++;
    if (count !== 16'h0098) $display("FAIL down_0098: got %h want %h", count, 16'h0098); else pass_cnt++;
    // Down from all-zeros.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef UDC_SATURATE_EN
    total_cnt++;
    if (count !== 16'h0000) $display("FAIL down_wrap_count: got %h want %h", count, 16'h0000); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL down_wrap_running: got %b want %b", running, 1'b0); else pass_cnt++;
`else
    total_cnt++;
    if (count !== 16'h9999) $display("FAIL down_wrap_count: got %h want %h", count, 16'h9999); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b1) $display("FAIL down_wrap_running: got %b want %b", running, 1'b1); else pass_cnt++;
`endif
    total_cnt++;
    if (tc !== 1'b1) $display("FAIL down_wrap_tc: got %b want %b", tc, 1'b1); else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL down_wrap_tc_drop: got %b want %b", tc, 1'b0); else pass_cnt++;
  endtask

  task automatic test_load();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hA3F1, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 16'h9391) $display("FAIL load_clamp: got %h want %h", count, 16'h9391); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL load_state_idle: got %b want %b", running, 1'b0); else pass_cnt++;
    // start in the load cycle is ignored
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 16'h0005) $display("FAIL load_with_start_count: got %h want %h", count, 16'h0005); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL load_with_start_running: got %b want %b", running, 1'b0); else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 16'h0005) $display("FAIL load_in_count: got %h want %h", count, 16'h0005); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b1) $display("FAIL load_in_count_running: got %b want %b", running, 1'b1); else pass_cnt++;
  endtask

  task automatic test_stop();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    // stop wins over start in IDLE; tick in IDLE ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    total_cnt++;
    if (running !== 1'b0) $display("FAIL idle_start_stop: got %b want %b", running, 1'b0); else pass_cnt++;
    total_cnt++;
    if (count !== 16'h0000) $display("FAIL idle_tick_ignored: got %h want %h", count, 16'h0000); else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    total_cnt++;
    if (count !== 16'h0042) $display("FAIL stop_tick_count: got %h want %h", count, 16'h0042); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL stop_tick_running: got %b want %b", running, 1'b0); else pass_cnt++;
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    total_cnt++;
    if (count !== 16'h0000) $display("FAIL second_stop_clear: got %h want %h", count, 16'h0000); else pass_cnt++;
    // now in IDLE: a start must resume running
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    total_cnt++;
    if (running !== 1'b1) $display("FAIL restart_running: got %b want %b", running, 1'b1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0517, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    total_cnt++;
    if (count !== 16'h0000) $display("FAIL mid_reset_count: got %h want %h", count, 16'h0000); else pass_cnt++;
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL mid_reset_tc: got %b want %b", tc, 1'b0); else pass_cnt++;
    total_cnt++;
    if (running !== 1'b0) $display("FAIL mid_reset_running: got %b want %b", running, 1'b0); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0; en = 1'b0; up = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    load_val = 16'h0000;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_count_down();
    test_load();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
